// File: rtl/act_pipe.sv
// Three-stage elastic activation pipe: sigmoid / tanh / ReLU / leaky ReLU on signed fixed point.
// Optional ACT_TANH_EN macro enables the tanh pre/post-scale; undefined, mode 01 behaves as sigmoid.
module act_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef logic signed [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    MODE_SIG   = 2'b00,
    MODE_TANH  = 2'b01,
    MODE_RELU  = 2'b10,
    MODE_LEAKY = 2'b11
  } mode_e;

  typedef enum logic [2:0] {SEG_0, SEG_1, SEG_2, SEG_3, SEG_4} seg_e;

  localparam word_t ONE     = word_t'(1) << FRAC_W;
  localparam word_t B       = word_t'((64'd1 << (FRAC_W + 3)) / 64'd5);
  localparam word_t E       = ONE << 3;
  localparam word_t NEG_B   = -B;
  localparam word_t NEG_E   = -E;
  localparam word_t ONE_8   = ONE >>> 3;
  localparam word_t ONE_2   = ONE >>> 1;
  localparam word_t SEVEN_8 = ONE - ONE_8;
`ifdef ACT_TANH_EN
  localparam word_t MOST_POS = word_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam word_t MOST_NEG = ~MOST_POS;
`endif

  typedef struct packed {
    mode_e mode;
    logic  last;
    word_t x;
    word_t xp;
    seg_e  seg;
  } s1_t;

  typedef struct packed {
    mode_e mode;
    logic  last;
    word_t x;
    word_t s;
  } s2_t;

  typedef struct packed {
    logic  last;
    word_t y;
  } s3_t;

  logic  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  s1_t   s1_q, s1_d;
  s2_t   s2_q, s2_d;
  s3_t   s3_q, s3_d;
  logic  ready1, ready2, ready3, accept;
  word_t xp_in, xp1, s_core, x2, s2v, y_post;
  seg_e  seg_in;

  // Ready ripples combinationally back from out_ready; a stage takes data when empty or draining.
  always_comb begin
    ready3   = !v3_q || out_ready;
    ready2   = !v2_q || ready3;
    ready1   = !v1_q || ready2;
    in_ready = rst_n && ready1;
    accept   = in_valid && in_ready;
    v1_d     = ready1 ? accept : v1_q;
    v2_d     = ready2 ? v1_q   : v2_q;
    v3_d     = ready3 ? v2_q   : v3_q;
  end

  // Stage 1: pre-scale and segment classification.
  always_comb begin
    xp_in = $signed(in_data);
`ifdef ACT_TANH_EN
    if (mode_e'(in_mode) == MODE_TANH) begin
      if (in_data[DATA_W-1] != in_data[DATA_W-2])
        xp_in = in_data[DATA_W-1] ? MOST_NEG : MOST_POS;
      else
        xp_in = $signed(in_data) <<< 1;
    end
`endif
    if (xp_in < NEG_E)      seg_in = SEG_0;
    else if (xp_in < NEG_B) seg_in = SEG_1;
    else if (xp_in < B)     seg_in = SEG_2;
    else if (xp_in < E)     seg_in = SEG_3;
    else                    seg_in = SEG_4;

    s1_d = s1_q;
    if (accept) begin
      s1_d.mode = mode_e'(in_mode);
      s1_d.last = in_last;
      s1_d.x    = $signed(in_data);
      s1_d.xp   = xp_in;
      s1_d.seg  = seg_in;
    end
  end

  // Stage 2: piecewise-linear sigmoid core.
  always_comb begin
    xp1 = s1_q.xp;
    case (s1_q.seg)
      SEG_0:   s_core = '0;
      SEG_1:   s_core = ONE_8 + (xp1 >>> 6);
      SEG_2:   s_core = ONE_2 + (xp1 >>> 2);
      SEG_3:   s_core = SEVEN_8 + (xp1 >>> 6);
      default: s_core = ONE;
    endcase

    s2_d = s2_q;
    if (v1_q && ready2) begin
      s2_d.mode = s1_q.mode;
      s2_d.last = s1_q.last;
      s2_d.x    = s1_q.x;
      s2_d.s    = s_core;
    end
  end

  // Stage 3: post-scale; ReLU modes use the original x carried down the pipe.
  always_comb begin
    x2  = s2_q.x;
    s2v = s2_q.s;
    case (s2_q.mode)
      MODE_RELU:  y_post = x2[DATA_W-1] ? '0 : x2;
      MODE_LEAKY: y_post = x2[DATA_W-1] ? (x2 >>> 3) : x2;
`ifdef ACT_TANH_EN
      MODE_TANH:  y_post = (s2v <<< 1) - ONE;
`endif
      default:    y_post = s2v;
    endcase

    s3_d = s3_q;
    if (v2_q && ready3) begin
      s3_d.last = s2_q.last;
      s3_d.y    = y_post;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = s3_q.y;
  assign out_last  = s3_q.last;

endmodule

// File: tb/tb_act_pipe.sv
// Self-checking bench for act_pipe: integer reference model, in-order scoreboard, stall and reset checks.
`timescale 1ns/1ps
module tb_act_pipe;
`ifdef ACT_TANH_EN
  localparam bit TANH_EN = 1'b1;
`else
  localparam bit TANH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;

  always #5 clk = ~clk;

  act_pipe #(.DATA_W(32), .FRAC_W(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [31:0] lit;
    bit          has_lit;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [1:0]  m;
    logic [31:0] lit;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        dir[18];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          n_out = 0;
  int          n_last = 0;
  bit          lat_chk = 1'b0;
  bit          rnd_ready = 1'b0;
  bit          cur_has_lit = 1'b0;
  logic [31:0] cur_lit = '0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference activation straight from the segment table, in 64-bit integers.
  function automatic logic [31:0] act_model(input logic [31:0] xin, input logic [1:0] mode);
    longint one_l = 64'sd1 << 24;
    longint b_l   = (one_l * 8) / 5;
    longint e_l   = 8 * one_l;
    longint x, xp, s, y;
    x  = longint'($signed(xin));
    xp = x;
    if (mode == 2'b01 && TANH_EN) begin
      xp = 2 * x;
      if (xp > 64'sd2147483647)  xp = 64'sd2147483647;
      if (xp < -64'sd2147483648) xp = -64'sd2147483648;
    end
    if (xp < -e_l)      s = 0;
    else if (xp < -b_l) s = one_l / 8 + (xp >>> 6);
    else if (xp < b_l)  s = one_l / 2 + (xp >>> 2);
    else if (xp < e_l)  s = (7 * one_l) / 8 + (xp >>> 6);
    else                s = one_l;
    case (mode)
      2'b00:   y = s;
      2'b01:   y = TANH_EN ? (2 * s - one_l) : s;
      2'b10:   y = (x < 0) ? 0 : x;
      default: y = (x < 0) ? (x >>> 3) : x;
    endcase
    return y[31:0];
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard: sampled on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          check("data", out_data, exp_q[0].data);
          check("last", 32'(out_last), 32'(exp_q[0].last));
          if (out_ready) begin
            if (exp_q[0].has_lit) check("literal", out_data, exp_q[0].lit);
            if (lat_chk) check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'd3);
            if (out_last) n_last++;
            n_out++;
            void'(exp_q.pop_front());
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (in_valid && in_ready)
        exp_q.push_back('{act_model(in_data, in_mode), in_last, cur_lit, cur_has_lit, cyc});
    end
  end

  task automatic send(input logic [31:0] x, input logic [1:0] m, input logic l,
                      input bit hl, input logic [31:0] lit);
    bit hs = 1'b0;
    if (hl) check("model_pin", act_model(x, m), lit);
    in_valid = 1'b1; in_data = x; in_mode = m; in_last = l;
    cur_has_lit = hl; cur_lit = lit;
    for (int t = 0; t < 500 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    if (!hs) check("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0; cur_has_lit = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] x;
    dir[0]  = '{32'h00000000, 2'b00, 32'h00800000};
    dir[1]  = '{32'h02000000, 2'b00, 32'h00E80000};
    dir[2]  = '{32'hF7000000, 2'b00, 32'h00000000};
    dir[3]  = '{32'h08000000, 2'b00, 32'h01000000};
    dir[4]  = '{32'h01999999, 2'b00, 32'h00E66666};
    dir[5]  = '{32'h01999998, 2'b00, 32'h00E66666};
    dir[6]  = '{32'hFE666667, 2'b00, 32'h00199999};
    dir[7]  = '{32'hFE666666, 2'b00, 32'h00199999};
    dir[8]  = '{32'h01000000, 2'b01, TANH_EN ? 32'h00D00000 : 32'h00C00000};
    dir[9]  = '{32'h00000000, 2'b01, TANH_EN ? 32'h00000000 : 32'h00800000};
    dir[10] = '{32'h7FFFFFFF, 2'b01, 32'h01000000};
    dir[11] = '{32'hFD000000, 2'b10, 32'h00000000};
    dir[12] = '{32'hF8000000, 2'b11, 32'hFF000000};
    dir[13] = '{32'h02000000, 2'b10, 32'h02000000};
    dir[14] = '{32'h03000000, 2'b11, 32'h03000000};
    dir[15] = '{32'hFD000000, 2'b11, 32'hFFA00000};
    dir[16] = '{32'hF8000000, 2'b10, 32'h00000000};
    dir[17] = '{32'h00800000, 2'b00, 32'h00A00000};

    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values, back to back with alternating modes, no backpressure.
    lat_chk = 1'b1;
    foreach (dir[i]) send(dir[i].x, dir[i].m, 1'b0, 1'b1, dir[i].lit);
    drain();
    lat_chk = 1'b0;

    // 16-sample burst under random backpressure, in_last on the final one.
    rnd_ready = 1'b1;
    n0 = n_out;
    n_last = 0;
    for (int i = 0; i < 16; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), (i == 15), 1'b0, '0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("bp_count", 32'(n_out - n0), 32'd16);
    check("bp_last_count", 32'(n_last), 32'd1);

    // Long random run with bubbles and stalls, biased toward the interesting range.
    n0 = n_out;
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      if ($urandom_range(0, 2) != 0) x = {{4{x[27]}}, x[27:0]};
      send(x, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, '0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("rand_count", 32'(n_out - n0), 32'd300);

    // Reset with three samples in flight.
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(32'h00400000 * i, 2'b00, 1'b0, 1'b0, '0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", out_data, 32'd0);
    check("rst_async_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    lat_chk = 1'b1;
    send(32'h02000000, 2'b00, 1'b1, 1'b1, 32'h00E80000);
    drain();
    lat_chk = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
